// File: rtl/mdio_pkg.sv
// Shared constants and state encoding for the Clause-22 MDIO management engine.
package mdio_pkg;

  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_RD    = 2'b10;
  localparam logic [1:0] ST_CODE  = 2'b01;

  localparam int PRE_LEN   = 32;
  localparam int HDR_LEN   = 14;
  localparam int TA_LEN    = 2;
  localparam int DATA_LEN  = 16;
  localparam int FRAME_LEN = PRE_LEN + HDR_LEN + TA_LEN + DATA_LEN;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
  } mdio_state_e;

  // Frame field that owns a given bit index (0 = first preamble bit).
  function automatic mdio_state_e phase_of(input logic [5:0] idx);
    if (idx < 6'(PRE_LEN))                       return S_PRE;
    else if (idx < 6'(PRE_LEN + HDR_LEN))        return S_HDR;
    else if (idx < 6'(PRE_LEN + HDR_LEN + TA_LEN)) return S_TA;
    else                                         return S_DATA;
  endfunction

endpackage

// File: rtl/mdio_master.sv
// Clause-22 MDIO frame engine: one register read or write per request,
// MDC generated from the management clock, read data returned with ready.
module mdio_master
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0,
  parameter int         MDC_HALF = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  addr,
  input  logic [15:0] wr_data,
  input  logic        rd_request,
  input  logic        wr_request,
  output logic        ready,
  output logic [15:0] rd_data,
  inout  wire         mdio_pin,
  output logic        mdc_pin
);

  mdio_state_e state_q, state_d;
  logic [3:0]  cnt_q;
  logic [5:0]  bit_q;
  logic [15:0] sh_q;
  logic [1:0]  op_q;
  logic [4:0]  reg_q;
  logic        oe_q, mdo_q;

  logic        in_frame, half_end, rise, fall, last_bit, accept, drv_bit;
  logic [5:0]  nxt_idx;
  logic [13:0] hdr;
  mdio_state_e nxt_phase;

  assign in_frame  = (state_q == S_PRE) || (state_q == S_HDR) ||
                     (state_q == S_TA)  || (state_q == S_DATA);
  assign half_end  = (cnt_q == 4'(MDC_HALF - 1));
  assign rise      = in_frame && !mdc_pin && half_end;
  // The falling MDC edge is also the read sample point and the bit boundary.
  assign fall      = in_frame && mdc_pin && half_end;
  assign last_bit  = (bit_q == 6'(FRAME_LEN - 1));
  assign nxt_idx   = bit_q + 6'd1;
  assign nxt_phase = phase_of(nxt_idx);
  assign accept    = (state_q == S_IDLE) && (rd_request || wr_request);
  assign hdr       = {ST_CODE, op_q, PHY_ADDR, reg_q};
  assign ready     = (state_q == S_IDLE);
  assign mdio_pin  = oe_q ? mdo_q : 1'bz;

  always_comb begin
    drv_bit = 1'b1;
    case (nxt_phase)
      S_PRE:   drv_bit = 1'b1;
      S_HDR:   drv_bit = hdr[4'(6'd45 - nxt_idx)];
      S_TA:    drv_bit = ~nxt_idx[0];  // write turnaround "10"
      S_DATA:  drv_bit = sh_q[15];
      default: drv_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:                      if (accept) state_d = S_PRE;
      S_PRE, S_HDR, S_TA, S_DATA:  if (fall) state_d = last_bit ? S_DONE : nxt_phase;
      S_DONE:                      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      op_q    <= OP_RD;
      reg_q   <= '0;
      oe_q    <= 1'b0;
      mdo_q   <= 1'b1;
      mdc_pin <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q   <= '0;
          mdc_pin <= 1'b0;
          if (accept) begin
            op_q  <= wr_request ? OP_WR : OP_RD;
            reg_q <= addr;
            sh_q  <= wr_data;
            bit_q <= '0;
            mdo_q <= 1'b1;
            oe_q  <= 1'b1;
          end
        end
        S_PRE, S_HDR, S_TA, S_DATA: begin
          cnt_q <= half_end ? 4'd0 : cnt_q + 4'd1;
          if (rise) mdc_pin <= 1'b1;
          if (fall) begin
            mdc_pin <= 1'b0;
            if (state_q == S_DATA && op_q == OP_RD)
              sh_q <= {sh_q[14:0], mdio_pin};
            if (last_bit) begin
              oe_q <= 1'b0;
              if (op_q == OP_RD) rd_data <= {sh_q[14:0], mdio_pin};
            end else begin
              bit_q <= nxt_idx;
              mdo_q <= drv_bit;
              if (nxt_phase == S_TA && op_q == OP_RD) oe_q <= 1'b0;
              if (nxt_phase == S_DATA && op_q == OP_WR) sh_q <= {sh_q[14:0], 1'b0};
            end
          end
        end
        default: begin
          oe_q    <= 1'b0;
          mdc_pin <= 1'b0;
        end
      endcase
    end
  end

endmodule
